bitmanip_seq_unit: RTL



---
 rtl/bitmanip_seq_unit_pkg.sv | 90 +++++++++
 rtl/bitmanip_seq_unit_if.sv | 29 ++
 rtl/bitmanip_seq_unit_clmul_iter_dp.sv | 61 ++++++
 rtl/bitmanip_seq_unit.sv | 77 +++++++
 4 files changed

// File: rtl/bitmanip_seq_unit_pkg.sv
// bitmanip_seq_unit_pkg: op/state types and bit-utility functions for the bit-manipulation unit
//    Exports bmu_op_t, bmu_state_t, gpr_addr_t and the permutation, clmul-select and op-class helpers.
package bitmanip_seq_unit_pkg;

   typedef enum logic [3:0] {
      XPERM8 = 4'd0,
      XPERM4 = 4'd1,
      ZIP    = 4'd2,
      UNZIP  = 4'd3,
      BREV8  = 4'd4,
      REV8   = 4'd5,
      CLMUL  = 4'd6,
      CLMULH = 4'd7,
      CLMULR = 4'd8
   } bmu_op_t;

   typedef enum logic [1:0] {IDLE, CALC, DONE} bmu_state_t;

   typedef logic [4:0] gpr_addr_t;

   // An index of 4 or more selects no byte, so its byte of the result is zero.
   function automatic logic [31:0] xperm8(input logic [31:0] lut, input logic [31:0] idx);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = (idx[8*i+2 +: 6] == '0) ? lut[{idx[8*i +: 2], 3'b000} +: 8] : 8'h00;
      return r;
   endfunction

   // An index of 8 or more selects no nibble, so its nibble of the result is zero.
   function automatic logic [31:0] xperm4(input logic [31:0] lut, input logic [31:0] idx);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         r[4*i +: 4] = !idx[4*i+3] ? lut[{idx[4*i +: 3], 2'b00} +: 4] : 4'h0;
      return r;
   endfunction

   function automatic logic [31:0] zip32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 16; i++) begin
         r[2*i]   = x[i];
         r[2*i+1] = x[i+16];
      end
      return r;
   endfunction

   function automatic logic [31:0] unzip32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 16; i++) begin
         r[i]    = x[2*i];
         r[i+16] = x[2*i+1];
      end
      return r;
   endfunction

   function automatic logic [31:0] brev8(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 8; j++)
            r[8*i+j] = x[8*i+7-j];
      return r;
   endfunction

   function automatic logic [31:0] rev8(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic is_clmul(input bmu_op_t op);
      return op == CLMUL || op == CLMULH || op == CLMULR;
   endfunction

   // Single-cycle results; clmul ops and undefined codes yield zero here.
   function automatic logic [31:0] perm_result(input bmu_op_t op, input logic [31:0] rs1, input logic [31:0] rs2);
      case (op)
         XPERM8:  return xperm8(rs1, rs2);
         XPERM4:  return xperm4(rs1, rs2);
         ZIP:     return zip32(rs1);
         UNZIP:   return unzip32(rs1);
         BREV8:   return brev8(rs1);
         REV8:    return rev8(rs1);
         default: return '0;
      endcase
   endfunction

   function automatic logic [31:0] clmul_select(input bmu_op_t op, input logic [63:0] acc);
      return op == CLMULH ? acc[63:32] : op == CLMULR ? acc[62:31] : acc[31:0];
   endfunction

endpackage

// File: rtl/bitmanip_seq_unit_if.sv
// bitmanip_seq_unit_if: request/response handshake bundle of the bit-manipulation unit
//    req_valid/req_ready/req_op/req_rs1/req_rs2/req_rd : issue side
//    resp_valid/resp_ready/resp_data/resp_rd           : writeback side
//    master = issuing stage, slave = the unit
interface bitmanip_seq_unit_if;
   import bitmanip_seq_unit_pkg::*;

   logic        req_valid;
   logic        req_ready;
   bmu_op_t     req_op;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   gpr_addr_t   req_rd;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   gpr_addr_t   resp_rd;

   modport master (
      output req_valid, req_op, req_rs1, req_rs2, req_rd, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_rd
   );

   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, req_rd, resp_ready,
      output req_ready, resp_valid, resp_data, resp_rd
   );

endinterface

// File: rtl/bitmanip_seq_unit_clmul_iter_dp.sv
// clmul_iter_dp: iterative carry-less multiply datapath (accumulator, slice shift/XOR, counter)
//    clk, rst_n : clock, asynchronous active-low reset
//    start      : latch rs1/rs2, clear accumulator and counter
//    en         : consume one BITS-wide slice of rs2 this cycle
//    done       : the slice consumed this cycle is the last one
//    acc        : 64-bit carry-less product accumulator
//    BITMANIP_CLMUL_EARLY_EXIT_EN: done also rises once the remaining rs2 bits are all zero
module clmul_iter_dp #(
   parameter int BITS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        en,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        done,
   output logic [63:0] acc
);

   localparam int CLMUL_ITERS = 32 / BITS;
   localparam int CW = CLMUL_ITERS > 1 ? $clog2(CLMUL_ITERS) : 1;

   // a_sh tracks rs1 pre-shifted to the current slice base; b has consumed slices shifted out.
   logic [63:0] a_sh;
   logic [31:0] b;
   logic [CW-1:0] cnt;
   logic [63:0] acc_nx;

   always_comb begin
      acc_nx = acc;
      for (int k = 0; k < BITS; k++)
         acc_nx = b[k] ? acc_nx ^ (a_sh << k) : acc_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         a_sh <= '0;
         b    <= '0;
         cnt  <= '0;
      end else if (start) begin
         acc  <= '0;
         a_sh <= {32'b0, rs1};
         b    <= rs2;
         cnt  <= '0;
      end else if (en) begin
         acc  <= acc_nx;
         a_sh <= a_sh << BITS;
         b    <= b >> BITS;
         cnt  <= cnt + 1'b1;
      end
   end

`ifdef BITMANIP_CLMUL_EARLY_EXIT_EN
   assign done = cnt == CW'(CLMUL_ITERS - 1) || (b >> BITS) == '0;
`else
   assign done = cnt == CW'(CLMUL_ITERS - 1);
`endif

endmodule

// File: rtl/bitmanip_seq_unit.sv
// bitmanip_seq_unit: valid/ready sequenced Zbkb/Zbkx/Zbkc execution unit, one op in flight
//    clk, rst_n : clock, asynchronous active-low reset
//    flush      : kills any in-flight or held op; blocks a same-cycle accept
//    bus        : bitmanip_seq_unit_if.slave request/response handshake
//    busy       : state is not IDLE
//    CLMUL_BITS_PER_CYCLE : rs2 bits consumed per CALC cycle (1, 2, 4, 8, 16, 32)
//    BITMANIP_CLMUL_EARLY_EXIT_EN: clmul leaves CALC once the remaining rs2 bits are zero
module bitmanip_seq_unit
   import bitmanip_seq_unit_pkg::*;
#(
   parameter int CLMUL_BITS_PER_CYCLE = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   bitmanip_seq_unit_if.slave   bus,
   output logic                 busy
);

   bmu_state_t  state, state_nx;
   bmu_op_t     op_q;
   logic [31:0] data_q;
   gpr_addr_t   rd_q;
   logic        accept;
   logic        dp_done;
   logic [63:0] acc;

   // A draining result frees the unit in the same cycle, allowing back-to-back issue.
   assign bus.req_ready = state == IDLE || (state == DONE && bus.resp_ready);
   assign accept = bus.req_valid && bus.req_ready && !flush;

   always_comb begin
      state_nx = state;
      if (flush)
         state_nx = IDLE;
      else if (accept)
         state_nx = is_clmul(bus.req_op) ? CALC : DONE;
      else if (state == CALC && dp_done)
         state_nx = DONE;
      else if (state == DONE && bus.resp_ready)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= XPERM8;
         data_q <= '0;
         rd_q   <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q   <= bus.req_op;
            data_q <= perm_result(bus.req_op, bus.req_rs1, bus.req_rs2);
            rd_q   <= bus.req_rd;
         end
      end
   end

   clmul_iter_dp #(.BITS(CLMUL_BITS_PER_CYCLE)) u_dp (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept && is_clmul(bus.req_op)),
      .en    (state == CALC),
      .rs1   (bus.req_rs1),
      .rs2   (bus.req_rs2),
      .done  (dp_done),
      .acc   (acc)
   );

   // The accumulator is stable outside CALC, so the clmul result is read straight from it.
   assign bus.resp_data  = is_clmul(op_q) ? clmul_select(op_q, acc) : data_q;
   assign bus.resp_rd    = rd_q;
   assign bus.resp_valid = state == DONE;
   assign busy           = state != IDLE;

endmodule
